// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: unloads bytes from the UART receiver and decodes fixed
// 5-byte command frames (header, address, data MSB, data LSB, checksum)
// into single-cycle register-write strobes. It also reports checksum and
// inter-byte timeout errors and counts accepted frames and errors.
module uart_cmd_rx #(
   parameter logic [7:0]  HDR_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CYC = 40000
) (
   input  logic        rxclk,
   input  logic        reset,
   input  logic        rx_empty,
   input  logic [7:0]  rx_data,
   output logic        uld_rx_data,
   output logic        wr_en,
   output logic [7:0]  wr_addr,
   output logic [15:0] wr_data,
   output logic        cksum_err,
   output logic        timeout_err,
   output logic        busy,
   output logic [15:0] pkt_cnt,
   output logic [7:0]  err_cnt
);

   localparam logic [1:0] FIDLE = 2'd0;
   localparam logic [1:0] FUNLD = 2'd1;
   localparam logic [1:0] FCAPT = 2'd2;

   localparam logic [2:0] SYNC = 3'd0;
   localparam logic [2:0] ADDR = 3'd1;
   localparam logic [2:0] DHI  = 3'd2;
   localparam logic [2:0] DLO  = 3'd3;
   localparam logic [2:0] CKS  = 3'd4;

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);

   logic [1:0]  fst_q, fst_d;
   logic        uld_q, uld_d;
   logic        byte_vld;

   logic [2:0]  frm_q, frm_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  dhi_q, dhi_d;
   logic [7:0]  dlo_q, dlo_d;
   logic [15:0] idle_q, idle_d;
   logic        wr_en_q, wr_en_d;
   logic [7:0]  wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        ck_q, ck_d;
   logic        to_q, to_d;
   logic [15:0] pkt_cnt_q;
   logic [7:0]  err_cnt_q;
   logic [7:0]  sum;

   // Fetch FSM next state; the unload pulse is registered from the state we enter.
   always_comb begin
      fst_d = fst_q;
      case (fst_q)
         FIDLE:   if (!rx_empty) fst_d = FUNLD;
         FUNLD:   fst_d = FCAPT;
         FCAPT:   fst_d = FIDLE;
         default: fst_d = FIDLE;
      endcase
      uld_d = (fst_d == FUNLD);
   end

   // The byte is taken straight off rx_data in the capture cycle.
   assign byte_vld = (fst_q == FCAPT);
   assign sum      = addr_q + dhi_q + dlo_q + rx_data;

   // Frame FSM, output strobes and idle counter; an arriving byte beats timeout expiry.
   always_comb begin
      frm_d     = frm_q;
      addr_d    = addr_q;
      dhi_d     = dhi_q;
      dlo_d     = dlo_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      ck_d      = 1'b0;
      to_d      = 1'b0;
      if (byte_vld) begin
         case (frm_q)
            SYNC: if (rx_data == HDR_BYTE) frm_d = ADDR;
            ADDR: begin
               addr_d = rx_data;
               frm_d  = DHI;
            end
            DHI: begin
               dhi_d = rx_data;
               frm_d = DLO;
            end
            DLO: begin
               dlo_d = rx_data;
               frm_d = CKS;
            end
            CKS: begin
               if (sum == 8'h00) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q;
                  wr_data_d = {dhi_q, dlo_q};
               end else begin
                  ck_d = 1'b1;
               end
               frm_d = SYNC;
            end
            default: frm_d = SYNC;
         endcase
      end else if (frm_q != SYNC && idle_q == TO_LIM) begin
         to_d  = 1'b1;
         frm_d = SYNC;
      end
      if (byte_vld || frm_q == SYNC) idle_d = '0;
      else                           idle_d = idle_q + 16'd1;
   end

   // State, data and strobe registers.
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         fst_q     <= FIDLE;
         uld_q     <= 1'b0;
         frm_q     <= SYNC;
         addr_q    <= '0;
         dhi_q     <= '0;
         dlo_q     <= '0;
         idle_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         ck_q      <= 1'b0;
         to_q      <= 1'b0;
      end else begin
         fst_q     <= fst_d;
         uld_q     <= uld_d;
         frm_q     <= frm_d;
         addr_q    <= addr_d;
         dhi_q     <= dhi_d;
         dlo_q     <= dlo_d;
         idle_q    <= idle_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         ck_q      <= ck_d;
         to_q      <= to_d;
      end
   end

   // Counters advance in the cycle their strobe is visible; err_cnt saturates.
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         pkt_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         if (wr_en_q) pkt_cnt_q <= pkt_cnt_q + 16'd1;
         if ((ck_q || to_q) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign uld_rx_data = uld_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign cksum_err   = ck_q;
   assign timeout_err = to_q;
   assign busy        = (frm_q != SYNC);
   assign pkt_cnt     = pkt_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule
